// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: opcode and FSM state encodings plus the default operand width.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NOT  = 3'd3,
      OP_NAND = 3'd4,
      OP_NOR  = 3'd5,
      OP_ADD  = 3'd6,
      OP_SUB  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// Single combinational 1-bit ALU stage: logic ops from primitive cells plus a full adder.
// Subtraction inverts b here; the caller presets the incoming carry to 1 for the +1.
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic a_bit,
   input  logic b_bit,
   input  logic cin,
   input  op_e  op,
   output logic r_bit,
   output logic cout_bit
);

   logic b_n;
   logic b_eff;
   logic and_r;
   logic or_r;
   logic xor_r;
   logic not_r;
   logic nand_r;
   logic nor_r;
   logic ab_x;
   logic sum;
   logic gen;
   logic prop_c;
   logic fa_cout;

   not_1  u_binv (.a(b_bit), .y(b_n));
   assign b_eff = (op == OP_SUB) ? b_n : b_bit;

   xor_2  u_fa_x1 (.a(a_bit), .b(b_eff), .y(ab_x));
   xor_2  u_fa_x2 (.a(ab_x),  .b(cin),   .y(sum));
   and_2  u_fa_g  (.a(a_bit), .b(b_eff), .y(gen));
   and_2  u_fa_p  (.a(ab_x),  .b(cin),   .y(prop_c));
   or_2   u_fa_c  (.a(gen),   .b(prop_c), .y(fa_cout));

   and_2  u_and  (.a(a_bit), .b(b_bit), .y(and_r));
   or_2   u_or   (.a(a_bit), .b(b_bit), .y(or_r));
   xor_2  u_xor  (.a(a_bit), .b(b_bit), .y(xor_r));
   not_1  u_not  (.a(a_bit), .y(not_r));
   nand_2 u_nand (.a(a_bit), .b(b_bit), .y(nand_r));
   nor_2  u_nor  (.a(a_bit), .b(b_bit), .y(nor_r));

   // Select the result bit for the opcode; carry only propagates for arithmetic ops
   always_comb begin
      r_bit    = 1'b0;
      cout_bit = 1'b0;
      case (op)
         OP_AND:  r_bit = and_r;
         OP_OR:   r_bit = or_r;
         OP_XOR:  r_bit = xor_r;
         OP_NOT:  r_bit = not_r;
         OP_NAND: r_bit = nand_r;
         OP_NOR:  r_bit = nor_r;
         OP_ADD, OP_SUB: begin
            r_bit    = sum;
            cout_bit = fa_cout;
         end
         default: r_bit = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_cells.sv
// Primitive logic cells shared across the lab designs; the ALU bit slice is built from these.
module and_2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a & b;
endmodule

module or_2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule

module xor_2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule

module not_1 (
   input  logic a,
   output logic y
);
   assign y = ~a;
endmodule

module nand_2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = ~(a & b);
endmodule

module nor_2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = ~(a | b);
endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: captures operands on start, processes one bit per cycle LSB first,
// then presents y/cout/zero with a one-cycle done pulse.
module bit_serial_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [WIDTH-1:0]   r_sh_q, r_sh_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               zero_q, zero_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               r_bit;
   logic               cout_bit;
   logic [WIDTH-1:0]   result;

   alu_bit_slice u_slice (
      .a_bit    (a_sh_q[0]),
      .b_bit    (b_sh_q[0]),
      .cin      (carry_q),
      .op       (op_q),
      .r_bit    (r_bit),
      .cout_bit (cout_bit)
   );

   // The current slice bit enters at the MSB, so after WIDTH shifts bit 0 lands at the LSB
   assign result = {r_bit, r_sh_q[WIDTH-1:1]};

   // Next-state logic: accept start only when idle or done, otherwise run the serial datapath
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      r_sh_d  = r_sh_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               op_d    = op_e'(op);
               a_sh_d  = a;
               b_sh_d  = b;
               r_sh_d  = '0;
               cnt_d   = '0;
               carry_d = (op_e'(op) == OP_SUB);
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            r_sh_d  = result;
            carry_d = cout_bit;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DONE;
               y_d     = result;
               cout_d  = cout_bit;
               zero_d  = (result == '0);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State and datapath registers; reset wins over every transition
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_AND;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         r_sh_q  <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         r_sh_q  <= r_sh_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign y    = y_q;
   assign cout = cout_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Testbench for bit_serial_alu (WIDTH=8): directed cases plus a randomized run against an arithmetic model.
module tb_bit_serial_alu;

   logic       clk;
   logic       rst;
   logic       start;
   logic [2:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] y;
   logic       cout;
   logic       zero;

   int nAsserts = 0;
   int nFail    = 0;

   bit_serial_alu #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .y     (y),
      .cout  (cout),
      .zero  (zero)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic reference: plain integer math, no bit-level modelling
   function automatic void model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z,
                                 output logic [7:0] r, output logic c);
      logic [8:0] s;
      c = 1'b0;
      case (o)
         3'd0: r = x & z;
         3'd1: r = x | z;
         3'd2: r = x ^ z;
         3'd3: r = ~x;
         3'd4: r = ~(x & z);
         3'd5: r = ~(x | z);
         3'd6: begin
            s = {1'b0, x} + {1'b0, z};
            r = s[7:0];
            c = s[8];
         end
         default: begin
            r = x - z;
            c = (x >= z);
         end
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present an operation with start high; the caller controls which cycle this lands in
   task automatic applyStimulus(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
      op    = o;
      a     = x;
      b     = z;
      start = 1'b1;
   endtask

   // Count edges from the accept edge until done; scramble inputs after capture.
   // intrudeAt>0 raises start with a different op/operands while the operation is running.
   task automatic waitDone(input int intrudeAt, output int lat, output int busyCnt, output bit got);
      lat     = 0;
      busyCnt = 0;
      got     = 1'b0;
      while (lat < 40 && !got) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            start = 1'b0;
            a     = 8'($urandom);
            b     = 8'($urandom);
            op    = 3'($urandom);
         end
         if (intrudeAt > 0 && lat == intrudeAt) begin
            start = 1'b1;
            op    = 3'd0;
            a     = 8'hFF;
            b     = 8'hFF;
         end
         if (intrudeAt > 0 && lat == intrudeAt + 1) start = 1'b0;
         if (busy) busyCnt++;
         if (done) got = 1'b1;
      end
   endtask

   task automatic runAndCheck(input string tag, input logic [2:0] o, input logic [7:0] x,
                              input logic [7:0] z, input bit fullCheck);
      int lat, busyCnt;
      bit got;
      logic [7:0] expY;
      logic       expC;
      model(o, x, z, expY, expC);
      @(negedge clk);
      applyStimulus(o, x, z);
      waitDone(0, lat, busyCnt, got);
      checkOutput({tag, "_done"}, 32'(got), 32'd1);
      checkOutput({tag, "_y"}, 32'(y), 32'(expY));
      checkOutput({tag, "_cout"}, 32'(cout), 32'(expC));
      checkOutput({tag, "_zero"}, 32'(zero), 32'(expY == 8'h00));
      if (fullCheck) begin
         checkOutput({tag, "_latency"}, 32'(lat), 32'd9);
         checkOutput({tag, "_busycycles"}, 32'(busyCnt), 32'd8);
         @(posedge clk);
         #1;
         checkOutput({tag, "_donepulse"}, 32'(done), 32'd0);
         checkOutput({tag, "_idlebusy"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int lat, busyCnt, dones;
      bit got;
      logic [7:0] expY, ra, rb;
      logic       expC;
      logic [2:0] ro;

      rst   = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      a     = 8'h00;
      b     = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_y", 32'(y), 32'd0);
      checkOutput("reset_cout", 32'(cout), 32'd0);
      checkOutput("reset_zero", 32'(zero), 32'd0);
      rst = 1'b0;

      runAndCheck("add_f0_20", 3'd6, 8'hF0, 8'h20, 1'b1);
      checkOutput("add_f0_20_yconst", 32'(y), 32'h10);
      runAndCheck("sub_eq", 3'd7, 8'h05, 8'h05, 1'b1);
      checkOutput("sub_eq_zconst", 32'(zero), 32'd1);
      runAndCheck("sub_borrow", 3'd7, 8'h03, 8'h05, 1'b1);
      checkOutput("sub_borrow_yconst", 32'(y), 32'hFE);
      runAndCheck("nand", 3'd4, 8'hAA, 8'h0F, 1'b1);
      checkOutput("nand_yconst", 32'(y), 32'hF5);
      runAndCheck("nor", 3'd5, 8'hAA, 8'h0F, 1'b1);
      checkOutput("nor_yconst", 32'(y), 32'h50);
      runAndCheck("not", 3'd3, 8'hAA, 8'h0F, 1'b1);
      checkOutput("not_yconst", 32'(y), 32'h55);

      // Start while busy must be ignored
      @(negedge clk);
      applyStimulus(3'd6, 8'h01, 8'h01);
      waitDone(3, lat, busyCnt, got);
      checkOutput("ignore_done", 32'(got), 32'd1);
      checkOutput("ignore_latency", 32'(lat), 32'd9);
      checkOutput("ignore_y", 32'(y), 32'h02);
      checkOutput("ignore_cout", 32'(cout), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("ignore_nostart", 32'(busy), 32'd0);

      // Reset mid-operation aborts without a done pulse
      @(negedge clk);
      applyStimulus(3'd6, 8'h37, 8'h11);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_y", 32'(y), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      rst   = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      checkOutput("abort_nodone", 32'(dones), 32'd0);
      runAndCheck("xor_after_abort", 3'd2, 8'hFF, 8'h0F, 1'b1);
      checkOutput("xor_after_abort_yconst", 32'(y), 32'hF0);

      // Back-to-back: second start presented during the DONE cycle
      @(negedge clk);
      applyStimulus(3'd6, 8'hF0, 8'h20);
      waitDone(0, lat, busyCnt, got);
      checkOutput("b2b_first_done", 32'(got), 32'd1);
      checkOutput("b2b_first_y", 32'(y), 32'h10);
      applyStimulus(3'd1, 8'h0C, 8'h03);
      waitDone(0, lat, busyCnt, got);
      checkOutput("b2b_second_done", 32'(got), 32'd1);
      checkOutput("b2b_spacing", 32'(lat), 32'd9);
      checkOutput("b2b_second_y", 32'(y), 32'h0F);
      checkOutput("b2b_second_cout", 32'(cout), 32'd0);

      // Randomized operations covering every opcode
      for (int i = 0; i < 200; i++) begin
         ro = 3'(i % 8);
         ra = 8'($urandom);
         rb = (i % 11 == 0) ? ra : 8'($urandom);
         model(ro, ra, rb, expY, expC);
         @(negedge clk);
         applyStimulus(ro, ra, rb);
         waitDone(0, lat, busyCnt, got);
         checkOutput("rand_done", 32'(got), 32'd1);
         checkOutput("rand_latency", 32'(lat), 32'd9);
         checkOutput("rand_y", 32'(y), 32'(expY));
         checkOutput("rand_cout", 32'(cout), 32'(expC));
         checkOutput("rand_zero", 32'(zero), 32'(expY == 8'h00));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
